// File: rtl/shift_arb_seq.sv
// Round-robin arbiter for two requesters feeding one 16-bit barrel shifter that runs in 4 fixed stages.
// Response is valid 5 cycles after accept and is held in DONE until rsp_rdy; nothing new is accepted meanwhile.
module shift_arb_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_vld,
  input  logic [15:0] req0_in,
  input  logic [3:0]  req0_cnt,
  input  logic [1:0]  req0_op,
  input  logic        req1_vld,
  input  logic [15:0] req1_in,
  input  logic [3:0]  req1_cnt,
  input  logic [1:0]  req1_op,
  output logic        req0_rdy,
  output logic        req1_rdy,
  output logic        rsp_vld,
  output logic [15:0] rsp_data,
  output logic        rsp_id,
  input  logic        rsp_rdy,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_ROR = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [1:0]  stage_q, stage_d;
  logic [15:0] work_q, work_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic        id_q, id_d;

  logic gnt0;
  logic gnt1;
  logic accept;

  // One stage of the log shifter: shift by 2^k in the captured direction.
  function automatic logic [15:0] shift_step(
    input logic [15:0] v,
    input logic [1:0]  op,
    input logic [1:0]  k
  );
    logic [3:0]  amt;
    logic [31:0] rot;
    logic [15:0] res;
    amt = 4'd1 << k;
    rot = {v, v} >> amt;
    case (op)
      OP_SLL:  res = v << amt;
      OP_ROR:  res = rot[15:0];
      OP_SRA:  res = $signed(v) >>> amt;
      OP_SRL:  res = v >> amt;
      default: res = v;
    endcase
    return res;
  endfunction

  // last_q=1 means req1 won last, so req0 takes the next tie.
  always_comb begin
    gnt0   = req0_vld && (!req1_vld || last_q);
    gnt1   = req1_vld && (!req0_vld || !last_q);
    accept = (state_q == IDLE) && (gnt0 || gnt1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      stage_q <= 2'd0;
      work_q  <= 16'h0000;
      cnt_q   <= 4'd0;
      op_q    <= 2'd0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      stage_q <= stage_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (stage_q == 2'd3) state_d = DONE;
      DONE:    if (rsp_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_d  = last_q;
    stage_d = stage_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    id_d    = id_q;
    if (accept) begin
      last_d  = gnt1;
      stage_d = 2'd0;
      work_d  = gnt1 ? req1_in  : req0_in;
      cnt_d   = gnt1 ? req1_cnt : req0_cnt;
      op_d    = gnt1 ? req1_op  : req0_op;
      id_d    = gnt1;
    end else if (state_q == SHIFT) begin
      stage_d = stage_q + 2'd1;
      if (cnt_q[stage_q]) begin
        work_d = shift_step(work_q, op_q, stage_q);
      end
    end
  end

  // rdy is also gated by rst_n so it stays low while reset is asserted.
  always_comb begin
    busy     = (state_q != IDLE);
    rsp_vld  = (state_q == DONE);
    rsp_data = rsp_vld ? work_q : 16'h0000;
    rsp_id   = rsp_vld ? id_q : 1'b0;
    req0_rdy = rst_n && (state_q == IDLE) && gnt0;
    req1_rdy = rst_n && (state_q == IDLE) && gnt1;
  end

endmodule

// File: tb/tb_shift_arb_seq.sv
// Directed and randomized bench for shift_arb_seq against a whole-count shift and arbitration model.
module tb_shift_arb_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_vld, req1_vld;
  logic [15:0] req0_in, req1_in;
  logic [3:0]  req0_cnt, req1_cnt;
  logic [1:0]  req0_op, req1_op;
  logic        req0_rdy, req1_rdy;
  logic        rsp_vld;
  logic [15:0] rsp_data;
  logic        rsp_id;
  logic        rsp_rdy;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int last_g = 1;

  always #5 clk = ~clk;

  shift_arb_seq dut (
    .clk(clk), .rst_n(rst_n),
    .req0_vld(req0_vld), .req0_in(req0_in), .req0_cnt(req0_cnt), .req0_op(req0_op),
    .req1_vld(req1_vld), .req1_in(req1_in), .req1_cnt(req1_cnt), .req1_op(req1_op),
    .req0_rdy(req0_rdy), .req1_rdy(req1_rdy),
    .rsp_vld(rsp_vld), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_rdy(rsp_rdy),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Whole shift by cnt in one step: 00 SLL, 01 ROR, 10 SRA, 11 SRL.
  function automatic logic [15:0] ref_shift(input logic [15:0] x, input int c, input logic [1:0] op);
    int u;
    int s;
    int r;
    logic signed [15:0] xs;
    u  = int'(x);
    xs = x;
    s  = xs;
    case (op)
      2'b00:   r = (u << c) & 32'hFFFF;
      2'b01:   r = ((u >> c) | (u << (16 - c))) & 32'hFFFF;
      2'b10:   r = (s >>> c) & 32'hFFFF;
      default: r = u >> c;
    endcase
    return r[15:0];
  endfunction

  task automatic scramble();
    req0_vld = 1'($urandom);
    req1_vld = 1'($urandom);
    req0_in  = 16'($urandom);
    req1_in  = 16'($urandom);
    req0_cnt = 4'($urandom);
    req1_cnt = 4'($urandom);
    req0_op  = 2'($urandom);
    req1_op  = 2'($urandom);
  endtask

  // Called at posedge+1 with the DUT in IDLE; leaves at posedge+1 after the response handshake.
  task automatic do_op(input logic v0, input logic v1,
                       input logic [15:0] i0, input logic [3:0] c0, input logic [1:0] o0,
                       input logic [15:0] i1, input logic [3:0] c1, input logic [1:0] o1,
                       input int stall);
    int g;
    logic [15:0] exp;
    req0_vld = v0; req0_in = i0; req0_cnt = c0; req0_op = o0;
    req1_vld = v1; req1_in = i1; req1_cnt = c1; req1_op = o1;
    rsp_rdy  = 1'($urandom);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_rsp_vld", rsp_vld, 0);
    chk("idle_rsp_data", rsp_data, 0);
    if (!v0 && !v1) begin
      chk("noreq_rdy0", req0_rdy, 0);
      chk("noreq_rdy1", req1_rdy, 0);
      @(posedge clk); #1;
      return;
    end
    g = (v0 && v1) ? (last_g == 1 ? 0 : 1) : (v1 ? 1 : 0);
    chk("grant_rdy0", req0_rdy, (g == 0) ? 1 : 0);
    chk("grant_rdy1", req1_rdy, (g == 1) ? 1 : 0);
    exp = (g == 1) ? ref_shift(i1, int'(c1), o1) : ref_shift(i0, int'(c0), o0);
    last_g = g;
    @(posedge clk); #1;
    for (int k = 1; k <= 4; k++) begin
      scramble();
      rsp_rdy = 1'($urandom);
      @(negedge clk);
      chk("shift_busy", busy, 1);
      chk("shift_rsp_vld", rsp_vld, 0);
      chk("shift_rsp_data", rsp_data, 0);
      chk("shift_rdy0", req0_rdy, 0);
      chk("shift_rdy1", req1_rdy, 0);
      @(posedge clk); #1;
    end
    for (int s = 0; s <= stall; s++) begin
      scramble();
      rsp_rdy = (s == stall);
      @(negedge clk);
      chk("done_rsp_vld", rsp_vld, 1);
      chk("done_rsp_data", rsp_data, exp);
      chk("done_rsp_id", rsp_id, 16'(g));
      chk("done_busy", busy, 1);
      chk("done_rdy0", req0_rdy, 0);
      chk("done_rdy1", req1_rdy, 0);
      @(posedge clk); #1;
    end
  endtask

  task automatic op1(input int id, input logic [15:0] x, input logic [3:0] c,
                     input logic [1:0] op, input int stall);
    if (id == 0) do_op(1'b1, 1'b0, x, c, op, 16'h0, 4'h0, 2'b00, stall);
    else         do_op(1'b0, 1'b1, 16'h0, 4'h0, 2'b00, x, c, op, stall);
  endtask

  initial begin
    rst_n = 1'b0;
    rsp_rdy = 1'b0;
    scramble();
    req0_vld = 1'b1;
    req1_vld = 1'b1;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_rsp_vld", rsp_vld, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rdy0", req0_rdy, 0);
    chk("rst_rdy1", req1_rdy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_g = 1;

    // Tie from reset: req0 first, then req1 six cycles later.
    do_op(1'b1, 1'b1, 16'h8000, 4'd15, 2'b10, 16'h0001, 4'd4, 2'b00, 0);
    do_op(1'b1, 1'b1, 16'h8000, 4'd15, 2'b10, 16'h0001, 4'd4, 2'b00, 0);

    op1(1, 16'h0001, 4'd4, 2'b00, 0);
    op1(1, 16'h000F, 4'd4, 2'b01, 0);
    op1(1, 16'h8000, 4'd1, 2'b11, 0);
    op1(1, 16'h4000, 4'd2, 2'b10, 0);
    for (int o = 0; o < 4; o++) op1(1, 16'hA5C3, 4'd0, 2'(o), 0);
    op1(0, 16'h1234, 4'd3, 2'b01, 3);
    do_op(1'b0, 1'b0, 16'h0, 4'h0, 2'b00, 16'h0, 4'h0, 2'b00, 0);

    // Reset during SHIFT stage 2 drops the op and restores the tie pointer.
    op1(0, 16'h00F0, 4'd1, 2'b00, 0);
    req0_vld = 1'b1; req0_in = 16'h8421; req0_cnt = 4'd7; req0_op = 2'b11;
    req1_vld = 1'b0;
    @(negedge clk);
    chk("pre_rst_rdy0", req0_rdy, 1);
    @(posedge clk); #1;
    scramble();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    req0_vld = 1'b1;
    req1_vld = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_rsp_vld", rsp_vld, 0);
    chk("midrst_rsp_data", rsp_data, 0);
    chk("midrst_rdy0", req0_rdy, 0);
    chk("midrst_rdy1", req1_rdy, 0);
    last_g = 1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    req0_vld = 1'b0;
    req1_vld = 1'b0;
    rsp_rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("postrst_no_rsp", rsp_vld, 0);
      chk("postrst_busy", busy, 0);
      @(posedge clk); #1;
    end
    do_op(1'b1, 1'b1, 16'h0F0F, 4'd5, 2'b01, 16'hF00F, 4'd3, 2'b10, 0);

    for (int n = 0; n < 40; n++) begin
      do_op(1'($urandom), 1'($urandom),
            16'($urandom), 4'($urandom), 2'($urandom),
            16'($urandom), 4'($urandom), 2'($urandom),
            int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_arb_seq.md
SHIFT_ARB_SEQ -- requirements
Module: shift_arb_seq

Interface
REQ-001 SHALL have exactly one clock and one reset; reset is asynchronous and active-low.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req0_vld / req1_vld  input  1 each  requester N presents an operation.
REQ-005 req0_in / req1_in  input  16 each  operand.
REQ-006 req0_cnt / req1_cnt  input  4 each  shift amount, 0-15.
REQ-007 req0_op / req1_op  input  2 each  op: 00 SLL, 01 ROR, 10 SRA, 11 SRL.
REQ-008 req0_rdy / req1_rdy  output  1 each  accept strobe; transfer occurs when vld and rdy are both high at a rising edge.
REQ-009 rsp_vld  output  1  result valid.
REQ-010 rsp_data  output  16  result.
REQ-011 rsp_id  output  1  requester index of the result.
REQ-012 rsp_rdy  input  1  consumer accepts result when rsp_vld and rsp_rdy are both high.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-015 IDLE: rdy SHALL be combinational, at most one high, only to the granted valid requester; all rdy SHALL be low in SHIFT and DONE.
REQ-016 Arbitration SHALL be round-robin: single valid requester wins; both valid -> the requester not granted last wins; last-grant pointer updates only on accept.
REQ-017 On accept SHALL capture in, cnt, op, id into internal registers, clear the stage counter to 0, and go IDLE->SHIFT.
REQ-018 SHIFT SHALL last exactly 4 cycles; in stage k (k=0..3) the working value shifts by 2^k positions if captured cnt[k]=1, else is held.
REQ-019 SLL SHALL zero-fill; SRL SHALL zero-fill; SRA SHALL replicate bit 15 of the working value; ROR SHALL rotate bits out of bit 0 into bit 15.
REQ-020 cnt=0 SHALL still take 4 SHIFT cycles and return the operand unchanged (fixed latency).
REQ-021 After stage 3, SHIFT->DONE; rsp_vld SHALL be high in DONE only, with rsp_data/rsp_id stable throughout DONE.
REQ-022 Latency: accept edge at cycle 0 -> rsp_vld high from cycle 5.
REQ-023 DONE->IDLE on rsp_vld&rsp_rdy; rsp_rdy low SHALL hold DONE indefinitely with no new accept (back-pressure).
REQ-024 No accept in the same cycle as a response handshake; minimum issue interval 6 cycles.
REQ-025 Requester inputs SHALL be ignored outside the accept cycle; changes during SHIFT/DONE SHALL not affect the result.
REQ-026 rsp_data SHALL be 0x0000 whenever rsp_vld is low.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, rsp_vld=0, rsp_data=0x0000, rsp_id=0, busy=0, all rdy low while rst_n low, internal registers 0, last-grant pointer = 1 (req0 wins first tie).
REQ-028 Reset in SHIFT or DONE SHALL discard the operation; no response is produced for it.
REQ-029 First accept possible in the first cycle rst_n is high.

Verification
REQ-030 req0 SRA in=0x8000 cnt=15, rsp_rdy=1 -> rsp_vld at cycle 5, rsp_data=0xFFFF, rsp_id=0.
REQ-031 req1 SLL 0x0001 cnt=4 -> 0x0010; ROR 0x000F cnt=4 -> 0xF000; SRL 0x8000 cnt=1 -> 0x4000; SRA 0x4000 cnt=2 -> 0x1000; any op cnt=0 -> operand unchanged, id=1.
REQ-032 Both vld high from reset, rsp_rdy=1 -> req0 granted first (rsp_id=0), req1 granted at next IDLE (rsp_id=1), ops 6 cycles apart.
REQ-033 rsp_rdy low 3 cycles in DONE -> rsp_vld/rsp_data/rsp_id held, busy=1, req rdy low; response taken on the 4th cycle, IDLE next.
REQ-034 rst_n pulsed low during SHIFT stage 2 -> busy=0 and rsp_vld=0 immediately, no response for that op, next request accepted normally.
REQ-035 Requester in/cnt/op changed during SHIFT -> result matches values captured at accept.
